// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: one holding buffer per result
// producer, round-robin drained to a registered write port.
module wb_port_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [REG_ADDR_WIDTH-1:0]           WrtBck_Addr,
  output logic [DATA_WIDTH-1:0]               WrtBck_Data,
  output logic                                Wr_En,
  output logic [IDW-1:0]                      grant_id,
  output logic [CNT_WIDTH-1:0]                conflict_cnt
);

  logic [NUM_REQ-1:0]        buf_full_q, buf_full_d;
  logic [REG_ADDR_WIDTH-1:0] buf_rd_q   [NUM_REQ];
  logic [REG_ADDR_WIDTH-1:0] buf_rd_d   [NUM_REQ];
  logic [DATA_WIDTH-1:0]     buf_data_q [NUM_REQ];
  logic [DATA_WIDTH-1:0]     buf_data_d [NUM_REQ];
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]        grant;
  logic                      gnt_vld;
  logic [IDW-1:0]            gnt_idx;

  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [IDW-1:0]            gid_q, gid_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  // A buffer accepts when empty or when it drains this cycle
  assign req_ready = ~buf_full_q | grant;

  // Round-robin search over full buffers starting at rr_ptr
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!gnt_vld && buf_full_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_vld)
      grant[gnt_idx] = 1'b1;
  end

  // Pointer advances past the winner; holds when idle
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      if (gnt_idx == IDW'(NUM_REQ-1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  // Buffer drain on grant, refill on handshake (refill wins)
  always_comb begin
    buf_full_d = buf_full_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i])
        buf_full_d[i] = 1'b0;
      if (req_valid[i] && req_ready[i]) begin
        buf_full_d[i] = 1'b1;
        buf_rd_d[i]   = req_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        buf_data_d[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write-port next state; x0 results drain without a write
  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    if (gnt_vld) begin
      wr_en_d = |buf_rd_q[gnt_idx];
      addr_d  = buf_rd_q[gnt_idx];
      data_d  = buf_data_q[gnt_idx];
      gid_d   = gnt_idx;
    end
  end

  // Saturating count of cycles with two or more buffers waiting
  always_comb begin
    cnt_d = cnt_q;
    if ($countones(buf_full_q) >= 2 && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full_q <= '0;
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      gid_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_rd_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      buf_full_q <= buf_full_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gid_q      <= gid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Wr_En        = wr_en_q;
  assign WrtBck_Addr  = addr_q;
  assign WrtBck_Data  = data_q;
  assign grant_id     = gid_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table, scoreboard of expected
// register-file writes, and hand sequences for timing corners.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wr_en;
  logic [1:0]  grant_id;
  logic [3:0]  conflict_cnt;

  int tests = 0;
  int fails = 0;
  int conf_exp = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .NUM_REQ(3), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .WrtBck_Addr(wb_addr), .WrtBck_Data(wb_data), .Wr_En(wr_en),
    .grant_id(grant_id), .conflict_cnt(conflict_cnt)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  gid;
  } wr_t;

  wr_t exp_q[$];

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    int          n;
    logic [5:0]  order;
    int          conf;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int g);
    wr_t e;
    e.rd   = req_rd[g*5 +: 5];
    e.data = req_data[g*32 +: 32];
    e.gid  = 2'(g);
    if (e.rd != 5'd0)
      exp_q.push_back(e);
  endtask

  task automatic idle();
    req_valid = '0;
    req_rd    = 15'($urandom);
    req_data  = {$urandom, $urandom, $urandom};
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    check({name, "_ready"}, 64'(req_ready), 64'h7);
  endtask

  // Scoreboard: every write must be the next expected one
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h gid=%0d expected none",
                 wb_addr, wb_data, grant_id);
      end else begin
        e = exp_q.pop_front();
        check("wb_write", 64'({wb_addr, wb_data, grant_id}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int na, nl, guard;
    logic [2:0] acc;

    tbl[0] = '{3'b111, {5'd6, 5'd5, 5'd4},
               {32'h6666_0006, 32'h5555_0005, 32'h4444_0004},
               3, {2'd0, 2'd2, 2'd1}, 2};
    tbl[1] = '{3'b101, {5'd9, 5'd0, 5'd7},
               {32'hC9C9_0009, 32'h0, 32'hC7C7_0007},
               2, {2'd0, 2'd0, 2'd2}, 1};
    tbl[2] = '{3'b010, {5'd0, 5'd0, 5'd0},
               {32'h0, 32'h0000_1234, 32'h0},
               1, {2'd0, 2'd0, 2'd1}, 0};
    tbl[3] = '{3'b011, {5'd0, 5'd11, 5'd10},
               {32'h0, 32'hD11D_0011, 32'hD10D_0010},
               2, {2'd0, 2'd1, 2'd0}, 1};

    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_addr", 64'(wb_addr), 64'd0);
    check("rst_data", 64'(wb_data), 64'd0);
    check("rst_gid", 64'(grant_id), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    check("rst_ready", 64'(req_ready), 64'h7);
    @(posedge clk);
    #1 reset = 1'b1;

    // All three at once from rr_ptr=0
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    push(0); push(1); push(2);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    check("h2_ready21_wait", 64'(req_ready[2:1]), 64'd0);
    @(negedge clk);
    check("h2_ready2_wait", 64'(req_ready[2]), 64'd0);
    drain(4);
    conf_exp = 2;
    check("h2_conflict", 64'(conflict_cnt), 64'(conf_exp));
    check_idle("h2");

    // Single ALU result latency
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd5};
    req_data  = {32'h0, 32'h0, 32'hDEAD_BEEF};
    push(0);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    check("h1_wr_en_edge0", 64'(wr_en), 64'd0);
    @(negedge clk);
    check("h1_wr_en_edge1", 64'(wr_en), 64'd1);
    @(negedge clk);
    check("h1_wr_en_after", 64'(wr_en), 64'd0);
    drain(2);
    check_idle("h1");

    // Table of one-cycle bursts with known grant order
    for (int t = 0; t < 4; t++) begin
      check("tbl_ready_pre", 64'(req_ready), 64'h7);
      req_valid = tbl[t].valid;
      req_rd    = tbl[t].rd;
      req_data  = tbl[t].data;
      for (int j = 0; j < tbl[t].n; j++)
        push(int'(tbl[t].order[j*2 +: 2]));
      @(posedge clk);
      #1 idle();
      drain(5);
      conf_exp += tbl[t].conf;
      check("tbl_conflict", 64'(conflict_cnt), 64'(conf_exp));
      check_idle("tbl");
    end

    // ALU and LSU streaming back-to-back
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{5'(i + 1), 32'hA000_0000 + 32'(i), 2'd0});
      exp_q.push_back('{5'(i + 16), 32'hB000_0000 + 32'(i), 2'd1});
    end
    na = 0;
    nl = 0;
    guard = 0;
    while ((na < 6 || nl < 6) && guard < 40) begin
      req_valid = {1'b0, nl < 6, na < 6};
      req_rd    = {5'd0, 5'(nl + 16), 5'(na + 1)};
      req_data  = {32'h0, 32'hB000_0000 + 32'(nl),
                   32'hA000_0000 + 32'(na)};
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0]) na++;
      if (acc[1]) nl++;
      guard++;
    end
    check("stream_accepted", 64'(na + nl), 64'd12);
    idle();
    drain(4);
    check_idle("stream");

    // Asynchronous reset with two buffers still full
    req_valid = 3'b111;
    req_rd    = {5'd22, 5'd21, 5'd20};
    req_data  = {32'hE2, 32'hE1, 32'hE0};
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1;
    check("h5_wr_en_pre", 64'(wr_en), 64'd1);
    reset = 1'b0;
    #1;
    check("h5_wr_en_async", 64'(wr_en), 64'd0);
    check("h5_ready_async", 64'(req_ready), 64'h7);
    check("h5_cnt_async", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    check("h5_wr_en_held", 64'(wr_en), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd7};
    req_data  = {32'h0, 32'h0, 32'h7777_0007};
    push(0);
    @(posedge clk);
    #1 idle();
    drain(4);
    check("h5_cnt_after", 64'(conflict_cnt), 64'd0);
    check_idle("h5");

    // Continuous x0 traffic to saturate the conflict counter
    for (int i = 1; i <= 21; i++) begin
      req_valid = 3'b111;
      req_rd    = '0;
      req_data  = {$urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      if (i == 10)
        check("sat_mid", 64'(conflict_cnt), 64'd9);
    end
    check("sat_full", 64'(conflict_cnt), 64'hF);
    idle();
    drain(4);
    check("sat_hold", 64'(conflict_cnt), 64'hF);
    check_idle("sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
